// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - register map, word width and FSM encoding for the MAX7219 word transmitter
package max7219_pkg;

    localparam int WORD_W = 16;

    localparam logic [7:0] REG_NOOP       = 8'h00;
    localparam logic [7:0] REG_DIGIT0     = 8'h01;
    localparam logic [7:0] REG_DIGIT1     = 8'h02;
    localparam logic [7:0] REG_DIGIT2     = 8'h03;
    localparam logic [7:0] REG_DIGIT3     = 8'h04;
    localparam logic [7:0] REG_DIGIT4     = 8'h05;
    localparam logic [7:0] REG_DIGIT5     = 8'h06;
    localparam logic [7:0] REG_DIGIT6     = 8'h07;
    localparam logic [7:0] REG_DIGIT7     = 8'h08;
    localparam logic [7:0] REG_DECODE     = 8'h09;
    localparam logic [7:0] REG_INTENSITY  = 8'h0A;
    localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
    localparam logic [7:0] REG_TEST       = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_HOLD,
        ST_GAP
    } tx_state_e;

    function automatic logic [WORD_W-1:0] make_word(input logic [7:0] addr, input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/max7219_word_tx_if.sv
// rtl/max7219_word_tx_if.sv - command word valid/ready handshake between sequencer and transmitter
interface max7219_word_tx_if;
    import max7219_pkg::*;

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);

endinterface

// File: rtl/max7219_word_tx_timer.sv
// rtl/max7219_word_tx_timer.sv - half_period_timer: reloadable down-counter timing one SCLK phase
module half_period_timer #(
    parameter int DIV_HALF = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic tick_o
);

    localparam int              CW       = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [CW-1:0]   LOAD_VAL = CW'(DIV_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Loading DIV_HALF-1 makes tick land on the last cycle of the phase, so DIV_HALF=1 ticks at once.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/max7219_word_tx.sv
// rtl/max7219_word_tx.sv - serializes one 16-bit MAX7219 command word per cs_n frame, MSB first
module max7219_word_tx
    import max7219_pkg::*;
#(
    parameter int DIV_HALF = 25,
    parameter int CS_GAP   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    max7219_word_tx_if.slave         word_if,
    output logic                     mosi,
    output logic                     sclk,
    output logic                     cs_n,
    output logic                     busy,
    output logic                     done
);

    localparam int            BW       = $clog2(WORD_W);
    localparam int            GW       = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmr_load, tmr_tick;
    logic              accept;

    assign accept = word_if.word_valid && ready_q;

    half_period_timer #(.DIV_HALF(DIV_HALF)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (tmr_load),
        .tick_o (tmr_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    shift_d   = word_if.word_in;
                    bit_cnt_d = BW'(WORD_W - 1);
                    cs_n_d    = 1'b0;
                    mosi_d    = word_if.word_in[WORD_W-1];
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP, ST_SHIFT_LO: begin
                if (tmr_tick) begin
                    sclk_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                // Next bit is driven together with the falling edge, keeping mosi stable at each rise.
                if (tmr_tick) begin
                    sclk_d   = 1'b0;
                    tmr_load = 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        shift_d   = shift_q << 1;
                        mosi_d    = shift_q[WORD_W-2];
                        state_d   = ST_SHIFT_LO;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_tick) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign word_if.word_ready = ready_q;
    assign mosi               = mosi_q;
    assign sclk               = sclk_q;
    assign cs_n               = cs_n_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
